mul_ctrl: RTL and testbench
===========================

# mul_ctrl

Sequencing controller for the CPU's pipelined signed multiplier core. It implements the RISC-V M-extension multiply ops MUL, MULH, MULHSU and MULHU, with these duties:
- extends operands to 33 bits;
- tracks in-flight requests in a sideband pipeline matched to the core's fixed latency;
- selects the low or high result word;
- applies backpressure by freezing the core via clock-enable.

It sits between the EX-stage issue logic and the multiplier core, and returns tagged results to writeback.

## Interface
Parameters:
- MUL_LAT, 3: pipeline depth of the multiplier core in cycles (≥1); the core registers its inputs on the first enabled edge.
- TAG_W, 5: width of the request tag (destination register index).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted this cycle when in_valid is also high.
- in_op  in  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- in_a, in_b  in  32  rs1, rs2.
- in_tag  in  TAG_W  tag returned with the result.
- flush  in  1  kills all in-flight requests (pipeline redirect).
- mul_ce  out  1  clock-enable to the multiplier core.
- mul_a, mul_b  out  33  extended operands to the core (signed 33x33).
- mul_p  in  66  core product, valid MUL_LAT enabled edges after operands.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_data  out  32  selected result word.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  any request in flight or presented at output.

## Operation
- **Operand extension (combinational from in_a/in_b):**
  - mul_a[32] = in_a[31] for all ops except MULHU, which uses 0.
  - mul_b[32] = in_b[31] for MUL and MULH; 0 for MULHSU and MULHU.
- **Result select:**
  - MUL: out_data = mul_p[31:0].
  - All others: out_data = mul_p[63:32].
  - mul_p[65:64] are ignored.
- **Sideband pipeline:** MUL_LAT stages, each holding vld, hi_sel and tag.
  - Stage 0 loads {accept, in_op != 00, in_tag}.
  - Stage i loads stage i-1.
  - All stages advance only when mul_ce = 1.
- **Outputs:**
  - out_valid = vld[MUL_LAT-1].
  - out_tag and the select come from the last stage.
- **Control:**
  - mul_ce = !out_valid | out_ready.
  - in_ready = mul_ce & !flush.
  - accept = in_valid & in_ready.
- **Bubbles:** when no request is accepted with mul_ce high, the core consumes don't-care operands. Stage 0 vld = 0, so the garbage never reaches out_valid.
- **Stall:** while out_valid & !out_ready:
  - mul_ce = 0, in_ready = 0;
  - core and sideband hold;
  - out_data, out_tag and out_valid are stable until accepted.
- **Flush:** on the edge where flush = 1, all vld bits clear, regardless of mul_ce. No request is accepted in a flush cycle.
  - A result presented with out_valid during the flush cycle may still handshake in that cycle if out_ready = 1.
  - It does not reappear afterwards.
- **Reset (rstn low, asynchronous):**
  - All vld bits go to 0; hi_sel and tags go to 0.
  - Hence out_valid = 0, busy = 0, mul_ce = 1 and in_ready = 1 (flush low).
  - Reset asserted mid-operation discards all in-flight requests with no output.
- busy = OR of all vld bits.

## Timing
- **Latency:** a request accepted in cycle k, with no stalls, gives out_valid high in cycle k+MUL_LAT.
- **Stalls:** each stalled cycle adds one cycle to the latency of every in-flight request.
- **Throughput:** one request per cycle while out_ready stays high.
- **Back-to-back and simultaneous events:**
  - An output handshake and an input accept in the same cycle are both legal.
  - Flush plus out_ready in the same cycle: the output handshake completes, then the pipeline is empty on the next cycle.
- **Combinational paths:**
  - in_ready and mul_ce depend combinationally on out_ready and flush.
  - No combinational path from in_valid to out_valid.

## Structure
- **Package mul_pkg:**
  - op encoding constants MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU;
  - default MUL_LAT;
  - a sideband struct {vld, hi_sel, tag}.
- **Sub-module mul_sideband_pipe:** parameterised MUL_LAT-deep shift register of the sideband struct, with enable, synchronous clear for flush, and async reset.
- **Top-level logic:** operand extension, result mux and ce/ready logic stay in mul_ctrl.
- **Integration:** the multiplier core is instantiated beside mul_ctrl by the EX stage, not inside it.

## Test plan
The bench uses MUL_LAT = 3 and a behavioural 33x33 signed core with CE.
1. **All four ops, all-ones operands:** in_a = in_b = 0xFFFFFFFF, issued with MUL, MULH, MULHU and MULHSU on consecutive cycles with tags 1–4.
   - Required out_data: 0x00000001, 0x00000000, 0xFFFFFFFE, 0xFFFFFFFF.
   - Tags 1–4 on consecutive cycles; first result 3 cycles after the first accept.
2. **Mixed-sign operands:** MULHSU with a = 0x80000000, b = 0x00000002 -> out_data 0xFFFFFFFF. MULH with a = 0x7FFFFFFF, b = 0x7FFFFFFF -> 0x3FFFFFFF.
3. **Backpressure:** stream 5 MULs with a = n, b = n (n = 1..5) and hold out_ready low for 4 cycles after the first result appears.
   - in_ready = 0 and out_data = 1 held stable during the stall.
   - After release, results 1, 4, 9, 16, 25 in order with no loss or duplication.
4. **Flush mid-flight:** issue 3 requests, assert flush one cycle later together with a new in_valid.
   - in_ready = 0 in the flush cycle.
   - No out_valid afterwards; busy = 0 on the next cycle.
   - A subsequent request completes normally.
5. **Async reset mid-flight:** drop rstn between clock edges with 2 requests in flight.
   - out_valid and busy go to 0 immediately; in_ready = 1.
   - No result emerges after rstn is released.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared encodings, default latency and the per-stage sideband record for the
// multiplier sequencing controller.
package mul_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    localparam int MUL_LAT_DEFAULT = 3;
    localparam int MUL_TAG_W       = 5;

    typedef struct packed {
        logic                 vld;
        logic                 hi_sel;
        logic [MUL_TAG_W-1:0] tag;
    } mul_sb_t;

    // Widen a 32-bit operand to 33 bits, replicating the sign only when signed.
    function automatic logic [32:0] mul_ext(input logic [31:0] v, input logic sgn);
        return {sgn & v[31], v};
    endfunction

endpackage

// File: rtl/mul_sideband_pipe.sv
// Shift register of sideband records that tracks each request through the
// multiplier core, advancing in lock-step with the core clock-enable.
module mul_sideband_pipe
    import mul_pkg::*;
#(
    parameter int LAT = MUL_LAT_DEFAULT
) (
    input  logic    clk,
    input  logic    rstn,
    input  logic    i_en,
    input  logic    i_clr,
    input  mul_sb_t i_sb,
    output mul_sb_t o_sb,
    output logic    o_any_vld
);

    mul_sb_t r_stage [LAT];

    // Advance on enable; a flush drops every valid bit even while the core is frozen.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LAT; i++) begin
                r_stage[i] <= '0;
            end
        end else if (i_clr) begin
            for (int i = 0; i < LAT; i++) begin
                r_stage[i].vld <= 1'b0;
            end
        end else if (i_en) begin
            r_stage[0] <= i_sb;
            for (int i = 1; i < LAT; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end else begin
            r_stage <= r_stage;
        end
    end

    // Any request still travelling through the core or waiting at the output.
    always_comb begin
        o_any_vld = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            o_any_vld = o_any_vld | r_stage[i].vld;
        end
    end

    assign o_sb = r_stage[LAT-1];

endmodule

// File: rtl/mul_ctrl.sv
// Sequencing controller for the pipelined 33x33 signed multiplier core:
// operand extension, in-flight tracking, result word select and backpressure.
module mul_ctrl
    import mul_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT,
    parameter int TAG_W   = MUL_TAG_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             mul_ce,
    output logic [32:0]      mul_a,
    output logic [32:0]      mul_b,
    input  logic [65:0]      mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    mul_sb_t w_sb_in;
    mul_sb_t w_sb_out;
    logic    w_sgn_a;
    logic    w_sgn_b;
    logic    w_ce;
    logic    w_accept;
    logic    w_unused;

    // Operand signedness per op: MULHSU treats rs2 as unsigned, MULHU both.
    always_comb begin
        w_sgn_a = 1'b1;
        w_sgn_b = 1'b1;
        case (in_op)
            MUL_OP_MUL:    begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            MUL_OP_MULH:   begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            MUL_OP_MULHSU: begin w_sgn_a = 1'b1; w_sgn_b = 1'b0; end
            MUL_OP_MULHU:  begin w_sgn_a = 1'b0; w_sgn_b = 1'b0; end
            default:       begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
        endcase
    end

    assign mul_a = mul_ext(in_a, w_sgn_a);
    assign mul_b = mul_ext(in_b, w_sgn_b);

    // The core and the sideband freeze together whenever a result is held unaccepted.
    assign w_ce     = !w_sb_out.vld | out_ready;
    assign w_accept = in_valid & w_ce & !flush;

    // Sideband record for the request entering the core this cycle.
    always_comb begin
        w_sb_in        = '0;
        w_sb_in.vld    = w_accept;
        w_sb_in.hi_sel = (in_op != MUL_OP_MUL);
        w_sb_in.tag    = MUL_TAG_W'(in_tag);
    end

    mul_sideband_pipe #(
        .LAT (MUL_LAT)
    ) u_sideband (
        .clk       (clk),
        .rstn      (rstn),
        .i_en      (w_ce),
        .i_clr     (flush),
        .i_sb      (w_sb_in),
        .o_sb      (w_sb_out),
        .o_any_vld (busy)
    );

    assign mul_ce    = w_ce;
    assign in_ready  = w_ce & !flush;
    assign out_valid = w_sb_out.vld;
    assign out_data  = w_sb_out.hi_sel ? mul_p[63:32] : mul_p[31:0];
    assign out_tag   = TAG_W'(w_sb_out.tag);

    assign w_unused = ^mul_p[65:64];

endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: behavioural core with clock-enable, a transaction-level
// model of in-flight requests, directed vector tables and randomized traffic.
module tb_mul_ctrl;
    import mul_pkg::*;

    localparam int LAT = 3;
    localparam int TW  = 5;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_op = 2'b00;
    logic [31:0]   in_a = 32'd0;
    logic [31:0]   in_b = 32'd0;
    logic [TW-1:0] in_tag = '0;
    logic          flush = 1'b0;
    logic          mul_ce;
    logic [32:0]   mul_a;
    logic [32:0]   mul_b;
    logic [65:0]   mul_p;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_data;
    logic [TW-1:0] out_tag;
    logic          busy;

    always #5 clk = ~clk;

    mul_ctrl #(.MUL_LAT(LAT), .TAG_W(TW)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
        .mul_ce(mul_ce), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .busy(busy)
    );

    // Behavioural multiplier core: registers operands on an enabled edge,
    // product visible LAT enabled edges later.
    logic signed [65:0] ext_a;
    logic signed [65:0] ext_b;
    logic [65:0]        core_p [LAT];
    assign ext_a = {{33{mul_a[32]}}, mul_a};
    assign ext_b = {{33{mul_b[32]}}, mul_b};
    always @(posedge clk) begin
        if (mul_ce) begin
            core_p[0] <= ext_a * ext_b;
            for (int i = 1; i < LAT; i++) core_p[i] <= core_p[i-1];
        end
    end
    assign mul_p = core_p[LAT-1];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: requests in flight, oldest first, with enabled-edge age.
    logic [31:0]   m_data [$];
    logic [TW-1:0] m_tag  [$];
    int            m_age  [$];

    // Results handed over by the DUT (data, tag, cycle of handshake).
    logic [31:0]   cap_data [$];
    logic [TW-1:0] cap_tag  [$];
    int            cap_cyc  [$];

    logic obs_ov, obs_rdy, obs_acc, obs_busy;
    logic [31:0] obs_data;

    typedef struct {
        logic [1:0]    op;
        logic [31:0]   a;
        logic [31:0]   b;
        logic [TW-1:0] tag;
        logic [31:0]   exp;
    } vec_t;
    vec_t vecs [6];

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, sp;
        longint unsigned ua, ub, up;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00:   begin sp = sa * sb; r = sp[31:0]; end
            2'b01:   begin sp = sa * sb; r = sp[63:32]; end
            2'b10:   begin sp = sa * longint'(ub); r = sp[63:32]; end
            default: begin up = ua * ub; r = up[63:32]; end
        endcase
        return r;
    endfunction

    function automatic logic m_ov();
        return (m_age.size() > 0) && (m_age[0] >= LAT);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_model();
        m_data.delete();
        m_tag.delete();
        m_age.delete();
    endtask

    // One clock cycle: inputs are already set; check, then advance the model.
    task automatic step();
        logic e_ov, e_ce, e_rdy, e_acc;
        #1;
        e_ov  = m_ov();
        e_ce  = !e_ov | out_ready;
        e_rdy = e_ce & !flush;
        e_acc = in_valid & e_rdy;
        check("in_ready", in_ready, e_rdy);
        check("mul_ce", mul_ce, e_ce);
        check("out_valid", out_valid, e_ov);
        check("busy", busy, m_age.size() > 0);
        if (e_ov) begin
            check("out_data", out_data, m_data[0]);
            check("out_tag", out_tag, m_tag[0]);
        end
        obs_ov   = out_valid;
        obs_rdy  = in_ready;
        obs_acc  = in_valid & in_ready;
        obs_busy = busy;
        obs_data = out_data;
        if (out_valid && out_ready) begin
            cap_data.push_back(out_data);
            cap_tag.push_back(out_tag);
            cap_cyc.push_back(cyc);
        end
        if (e_ov && out_ready) begin
            void'(m_data.pop_front());
            void'(m_tag.pop_front());
            void'(m_age.pop_front());
        end
        if (flush) begin
            clear_model();
        end else if (e_ce) begin
            foreach (m_age[i]) m_age[i] = m_age[i] + 1;
            if (e_acc) begin
                m_data.push_back(ref_result(in_op, in_a, in_b));
                m_tag.push_back(in_tag);
                m_age.push_back(1);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_cap();
        cap_data.delete();
        cap_tag.delete();
        cap_cyc.delete();
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TW-1:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
    endtask

    initial begin
        int start_cyc, n, stall;
        logic seen;

        vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h00000001};
        vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000000};
        vecs[2] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE};
        vecs[3] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF};
        vecs[4] = '{2'b10, 32'h80000000, 32'h00000002, 5'd5, 32'hFFFFFFFF};
        vecs[5] = '{2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd6, 32'h3FFFFFFF};

        // Reset state
        #2 rstn = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_mul_ce", mul_ce, 1'b1);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rstn = 1'b1;

        // Vector table: all ops, all-ones and mixed-sign operands, back to back
        out_ready = 1'b1;
        clear_cap();
        start_cyc = cyc;
        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("vec_count", cap_data.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < cap_data.size()) begin
                check("vec_data", cap_data[i], vecs[i].exp);
                check("vec_tag", cap_tag[i], vecs[i].tag);
                check("vec_cycle", cap_cyc[i] - start_cyc, LAT + i);
            end
        end

        // Backpressure: 5 MULs, output stalled 4 cycles from the first result
        clear_cap();
        n = 1;
        seen = 1'b0;
        stall = 0;
        for (int c = 0; c < 40; c++) begin
            if (n <= 5) issue(2'b00, 32'(n), 32'(n), TW'(n));
            else in_valid = 1'b0;
            if (!seen && m_ov()) begin
                seen = 1'b1;
                stall = 4;
            end
            out_ready = (stall == 0);
            step();
            if (stall > 0) begin
                check("bp_in_ready", obs_rdy, 1'b0);
                check("bp_hold_data", obs_data, 32'd1);
                check("bp_hold_valid", obs_ov, 1'b1);
                stall--;
            end
            if (obs_acc) n++;
        end
        out_ready = 1'b1;
        check("bp_count", cap_data.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < cap_data.size()) check("bp_data", cap_data[i], 32'((i + 1) * (i + 1)));
        end

        // Flush mid-flight together with a new request
        for (int i = 0; i < 3; i++) begin
            issue(2'b00, 32'(i + 2), 32'd3, TW'(i));
            step();
        end
        issue(2'b01, 32'd11, 32'd13, 5'd7);
        flush = 1'b1;
        step();
        check("flush_in_ready", obs_rdy, 1'b0);
        flush = 1'b0;
        in_valid = 1'b0;
        clear_cap();
        step();
        check("flush_busy", obs_busy, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("flush_no_out", obs_ov, 1'b0);
        end
        issue(2'b00, 32'd6, 32'd7, 5'd9);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("post_flush_count", cap_data.size(), 1);
        if (cap_data.size() > 0) begin
            check("post_flush_data", cap_data[0], 32'd42);
            check("post_flush_tag", cap_tag[0], 5'd9);
        end

        // Asynchronous reset with two requests in flight
        clear_cap();
        issue(2'b00, 32'd5, 32'd5, 5'd3);
        step();
        issue(2'b11, 32'd8, 32'd9, 5'd4);
        step();
        in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_in_ready", in_ready, 1'b1);
        clear_model();
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("arst_no_out", obs_ov, 1'b0);
        end
        check("arst_count", cap_data.size(), 0);

        // Randomized traffic against the reference model
        for (int c = 0; c < 500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_op     = 2'($urandom_range(0, 3));
            in_a      = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            in_b      = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            in_tag    = TW'($urandom_range(0, 31));
            step();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("drain_busy", obs_busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
